line_window_gen: RTL and testbench

Parametrised successor to the basic 3x3 line buffer. It turns a raster pixel stream into KxK sliding windows and adds:
- valid/ready backpressure on both sides
- multi-channel pixels
- runtime image width and height
- frame and line markers on input and output

It sits between the pixel source (DMA/video-in) and the kernel datapath (convolution, morphology, median). It emits "valid"-region windows only, so the output image is (W-K+1) x (H-K+1).

---
 rtl/line_window_gen.sv | 144 ++++++++++++++
 tb/tb_line_window_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_gen.sv
// Raster pixel stream to KxK sliding windows (valid region only) with valid/ready on both sides.
// Optional LINE_WINDOW_GEN_EOL_CHECK_EN adds eol_err and realigns the counters on s_eol.
module line_window_gen #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned CHANNELS      = 1,
    parameter int unsigned KERNEL_SIZE   = 3,
    parameter int unsigned MAX_IMG_WIDTH = 1920,
    parameter int unsigned CW            = $clog2(MAX_IMG_WIDTH + 1)
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic [CW-1:0]                                         img_width,
    input  logic [CW-1:0]                                         img_height,
    input  logic                                                  s_valid,
    output logic                                                  s_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0]                        s_data,
    input  logic                                                  s_sof,
    input  logic                                                  s_eol,
    output logic                                                  m_valid,
    input  logic                                                  m_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_WIDTH-1:0] m_window,
    output logic                                                  m_sof,
    output logic                                                  m_eol,
    output logic                                                  m_eof,
`ifdef LINE_WINDOW_GEN_EOL_CHECK_EN
    output logic                                                  eol_err,
`endif
    output logic                                                  cfg_err
);

    localparam int unsigned K  = KERNEL_SIZE;
    localparam int unsigned NR = K - 1;
    localparam int unsigned PW = CHANNELS * DATA_WIDTH;
    localparam int unsigned WW = K * K * PW;
    localparam int unsigned AW = (MAX_IMG_WIDTH > 1) ? $clog2(MAX_IMG_WIDTH) : 1;

    logic [CW-1:0] x_q, y_q, wid_q, hgt_q;
    logic          frame_ok_q;
    logic [WW-1:0] win_q;

    logic          accept_c;
    logic [CW-1:0] cur_x_c, cur_y_c, cur_w_c, cur_h_c;
    logic          cfg_ok_c, frame_ok_c, last_x_c, last_y_c, wrap_c, emit_c, in_range_c, ram_we_c;
    logic [AW-1:0] ram_addr_c;
    logic [PW-1:0] ram_rd [NR];
    logic [K*PW-1:0] col_c;
    logic [WW-1:0] win_next_c;

    assign s_ready  = rst_n && (!m_valid || m_ready);
    assign accept_c = s_valid && s_ready;
    assign m_window = win_q;

    // An SOF beat acts as (0,0) of a frame with the freshly presented geometry.
    assign cur_x_c    = s_sof ? '0 : x_q;
    assign cur_y_c    = s_sof ? '0 : y_q;
    assign cur_w_c    = s_sof ? img_width  : wid_q;
    assign cur_h_c    = s_sof ? img_height : hgt_q;
    assign cfg_ok_c   = (img_width >= CW'(K)) && (img_width <= CW'(MAX_IMG_WIDTH)) &&
                        (img_height >= CW'(K));
    assign frame_ok_c = s_sof ? cfg_ok_c : frame_ok_q;
    assign last_x_c   = (cur_x_c == cur_w_c - CW'(1));
    assign last_y_c   = (cur_y_c == cur_h_c - CW'(1));
    assign emit_c     = frame_ok_c && (cur_x_c >= CW'(K - 1)) && (cur_y_c >= CW'(K - 1));
    assign in_range_c = (cur_x_c < CW'(MAX_IMG_WIDTH));
    assign ram_we_c   = accept_c && in_range_c;
    assign ram_addr_c = AW'(cur_x_c);

`ifdef LINE_WINDOW_GEN_EOL_CHECK_EN
    assign wrap_c = last_x_c || s_eol;
`else
    logic unused_eol;
    assign unused_eol = s_eol;
    assign wrap_c     = last_x_c;
`endif

    // Line RAM j holds the row j+1 lines above the incoming one; a beat shifts column x upward.
    for (genvar j = 0; j < NR; j++) begin : g_line
        logic [PW-1:0] mem [MAX_IMG_WIDTH];
        logic [PW-1:0] wd;
        if (j == 0) begin : g_first
            assign wd = s_data;
        end else begin : g_next
            assign wd = ram_rd[j-1];
        end
        always_ff @(posedge clk) begin
            if (ram_we_c) mem[ram_addr_c] <= wd;
        end
        assign ram_rd[j] = in_range_c ? mem[ram_addr_c] : '0;
    end

    // New column: oldest row on top, incoming pixel at the bottom.
    for (genvar r = 0; r < K; r++) begin : g_col
        if (r == K - 1) begin : g_new
            assign col_c[r*PW +: PW] = s_data;
        end else begin : g_old
            assign col_c[r*PW +: PW] = ram_rd[K-2-r];
        end
        assign win_next_c[r*K*PW +: K*PW] = {col_c[r*PW +: PW], win_q[r*K*PW + PW +: (K-1)*PW]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            wid_q      <= '0;
            hgt_q      <= '0;
            frame_ok_q <= 1'b0;
            win_q      <= '0;
            m_valid    <= 1'b0;
            m_sof      <= 1'b0;
            m_eol      <= 1'b0;
            m_eof      <= 1'b0;
            cfg_err    <= 1'b0;
`ifdef LINE_WINDOW_GEN_EOL_CHECK_EN
            eol_err    <= 1'b0;
`endif
        end else if (accept_c) begin
            if (wrap_c) begin
                x_q <= '0;
                y_q <= last_y_c ? '0 : cur_y_c + CW'(1);
            end else begin
                x_q <= cur_x_c + CW'(1);
                y_q <= cur_y_c;
            end
            if (s_sof) begin
                wid_q      <= img_width;
                hgt_q      <= img_height;
                frame_ok_q <= cfg_ok_c;
                if (!cfg_ok_c) cfg_err <= 1'b1;
            end
`ifdef LINE_WINDOW_GEN_EOL_CHECK_EN
            if (frame_ok_c && (s_eol != last_x_c)) eol_err <= 1'b1;
`endif
            win_q   <= win_next_c;
            m_valid <= emit_c;
            m_sof   <= emit_c && (cur_x_c == CW'(K - 1)) && (cur_y_c == CW'(K - 1));
            m_eol   <= emit_c && last_x_c;
            m_eof   <= emit_c && last_x_c && last_y_c;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench for line_window_gen: K=3 mono instance and a K=5 three-channel instance.
module tb_line_window_gen;

    localparam int unsigned CWA = $clog2(1920 + 1);
    localparam int unsigned CWB = $clog2(16 + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [CWA-1:0] a_w, a_h;
    logic           a_s_valid, a_s_ready, a_s_sof, a_s_eol;
    logic [7:0]     a_s_data;
    logic           a_m_valid, a_m_ready, a_m_sof, a_m_eol, a_m_eof, a_cfg_err;
    logic [71:0]    a_m_window;
`ifdef LINE_WINDOW_GEN_EOL_CHECK_EN
    logic           a_eol_err;
`endif

    logic [CWB-1:0] b_w, b_h;
    logic           b_s_valid, b_s_ready, b_s_sof, b_s_eol;
    logic [23:0]    b_s_data;
    logic           b_m_valid, b_m_ready, b_m_sof, b_m_eol, b_m_eof, b_cfg_err;
    logic [599:0]   b_m_window;
`ifdef LINE_WINDOW_GEN_EOL_CHECK_EN
    logic           b_eol_err;
`endif

    line_window_gen u_dut_a (
        .clk(clk), .rst_n(rst_n), .img_width(a_w), .img_height(a_h),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_sof(a_s_sof), .s_eol(a_s_eol),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_window(a_m_window),
        .m_sof(a_m_sof), .m_eol(a_m_eol), .m_eof(a_m_eof),
`ifdef LINE_WINDOW_GEN_EOL_CHECK_EN
        .eol_err(a_eol_err),
`endif
        .cfg_err(a_cfg_err)
    );

    line_window_gen #(.DATA_WIDTH(8), .CHANNELS(3), .KERNEL_SIZE(5), .MAX_IMG_WIDTH(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .img_width(b_w), .img_height(b_h),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_sof(b_s_sof), .s_eol(b_s_eol),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_window(b_m_window),
        .m_sof(b_m_sof), .m_eol(b_m_eol), .m_eof(b_m_eof),
`ifdef LINE_WINDOW_GEN_EOL_CHECK_EN
        .eol_err(b_eol_err),
`endif
        .cfg_err(b_cfg_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int acc_cnt  = 0;
    int sr_viol  = 0;
    bit bp_en    = 1'b0;

    logic [71:0]  qa_win[$];
    logic [2:0]   qa_mk[$];
    int           qa_beat[$];
    logic [599:0] qb_win[$];
    logic [2:0]   qb_mk[$];

    task automatic check(input string tag, input logic [639:0] act, input logic [639:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [71:0] win_a(input int w, input int x, input int y);
        logic [71:0] v;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[(r*3+c)*8 +: 8] = 8'((y - 2 + r) * w + (x - 2 + c));
        return v;
    endfunction

    function automatic logic [599:0] win_b(input int x, input int y);
        logic [599:0] v;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                for (int ch = 0; ch < 3; ch++)
                    v[((r*5+c)*3+ch)*8 +: 8] = 8'((y - 4 + r) * 7 + (x - 4 + c) + 64 * ch);
        return v;
    endfunction

    // Output capture on the falling edge: a transfer happens at the following rising edge.
    always @(negedge clk) begin
        if (a_m_valid && a_m_ready) begin
            qa_win.push_back(a_m_window);
            qa_mk.push_back({a_m_sof, a_m_eol, a_m_eof});
            qa_beat.push_back(acc_cnt);
        end
        if (a_m_valid && !a_m_ready && a_s_ready) sr_viol++;
        if (b_m_valid && b_m_ready) begin
            qb_win.push_back(b_m_window);
            qb_mk.push_back({b_m_sof, b_m_eol, b_m_eof});
        end
    end

    always @(posedge clk) begin
        #1;
        a_m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic push_a(input logic [7:0] d, input bit sof, input bit eol, input bit rnd);
        int guard = 0;
        if (rnd) while ($urandom_range(0, 9) >= 7) begin @(posedge clk); #1; end
        a_s_valid = 1'b1; a_s_data = d; a_s_sof = sof; a_s_eol = eol;
        forever begin
            @(negedge clk);
            if (a_s_ready) begin
                @(posedge clk); #1;
                acc_cnt++;
                break;
            end
            @(posedge clk); #1;
            guard++;
            if (guard > 1000) begin check("a_push_timeout", guard, 0); break; end
        end
        a_s_valid = 1'b0; a_s_sof = 1'b0; a_s_eol = 1'b0;
    endtask

    task automatic send_a(input int w, input int h, input int n, input int eolw, input bit rnd);
        a_w = CWA'(w); a_h = CWA'(h);
        for (int i = 0; i < n; i++)
            push_a(8'(i), i == 0, (eolw > 0) && (i % eolw == eolw - 1), rnd);
    endtask

    task automatic push_b(input logic [23:0] d, input bit sof);
        int guard = 0;
        b_s_valid = 1'b1; b_s_data = d; b_s_sof = sof;
        forever begin
            @(negedge clk);
            if (b_s_ready) begin @(posedge clk); #1; break; end
            @(posedge clk); #1;
            guard++;
            if (guard > 1000) begin check("b_push_timeout", guard, 0); break; end
        end
        b_s_valid = 1'b0; b_s_sof = 1'b0;
    endtask

    task automatic wait_a(input int n);
        int t = 0;
        while (qa_win.size() < n && t < 3000) begin @(posedge clk); t++; end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic wait_b(input int n);
        int t = 0;
        while (qb_win.size() < n && t < 3000) begin @(posedge clk); t++; end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        qa_win.delete(); qa_mk.delete(); qa_beat.delete();
        qb_win.delete(); qb_mk.delete();
    endtask

    task automatic check_frame_a(input string tag, input int w, input int h);
        int i = 0;
        check({tag, "_count"}, qa_win.size(), (w - 2) * (h - 2));
        for (int y = 2; y < h; y++)
            for (int x = 2; x < w; x++) begin
                if (i < qa_win.size()) begin
                    check($sformatf("%s_win%0d", tag, i), qa_win[i], win_a(w, x, y));
                    check($sformatf("%s_mk%0d", tag, i), qa_mk[i],
                          {x == 2 && y == 2, x == w - 1, x == w - 1 && y == h - 1});
                end
                i++;
            end
    endtask

    initial begin
        int n_eol;
        logic [71:0] hand;
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
        hand = '0; n_eol = 0;
    end

    initial begin
        int n_eol;
        logic [71:0] hand;
        a_w = '0; a_h = '0; a_s_valid = 0; a_s_data = '0; a_s_sof = 0; a_s_eol = 0; a_m_ready = 1;
        b_w = '0; b_h = '0; b_s_valid = 0; b_s_data = '0; b_s_sof = 0; b_s_eol = 0; b_m_ready = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", a_s_ready, 0);
        check("rst_m_valid", a_m_valid, 0);
        check("rst_m_window", a_m_window, 0);
        check("rst_markers", {a_m_sof, a_m_eol, a_m_eof}, 0);
        check("rst_cfg_err", a_cfg_err, 0);
        check("rst_b_m_valid", b_m_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain ramp, downstream always ready
        send_a(8, 8, 64, 8, 0);
        wait_a(36);
        check_frame_a("ramp", 8, 8);
        hand = 72'h121110_0a0908_020100;
        if (qa_win.size() > 0) check("ramp_first_hand", qa_win[0], hand);
        hand = 72'h3f3e3d_373635_2f2e2d;
        if (qa_win.size() > 35) check("ramp_last_hand", qa_win[35], hand);
        n_eol = 0;
        foreach (qa_mk[i]) if (qa_mk[i][1]) n_eol++;
        check("ramp_eol_count", n_eol, 6);

        // Random backpressure on both sides
        clear_q(); sr_viol = 0; bp_en = 1'b1;
        send_a(8, 8, 64, 8, 1);
        wait_a(36);
        bp_en = 1'b0;
        check_frame_a("bp", 8, 8);
        check("bp_sready_rule", sr_viol, 0);

        // Three channels, 5x5 kernel, 7x6 image
        b_w = CWB'(7); b_h = CWB'(6);
        for (int i = 0; i < 42; i++) push_b({8'(i + 128), 8'(i + 64), 8'(i)}, i == 0);
        wait_b(6);
        check("mc_count", qb_win.size(), 6);
        for (int i = 0; i < qb_win.size() && i < 6; i++) begin
            check($sformatf("mc_win%0d", i), qb_win[i], win_b(4 + i % 3, 4 + i / 3));
            check($sformatf("mc_mk%0d", i), qb_mk[i], {i == 0, i % 3 == 2, i == 5});
        end
        if (qb_win.size() > 0) begin
            check("mc_w0_r4c4_ch2", qb_win[0][592 +: 8], 8'd160);
            check("mc_w0_r4c0_ch2", qb_win[0][496 +: 8], 8'd156);
            check("mc_w0_r0c0_ch1", qb_win[0][8 +: 8], 8'd64);
        end

        // Bad width, then a mid-stream SOF with a valid geometry
        clear_q();
        send_a(2, 8, 10, 2, 0);
        repeat (4) @(posedge clk); #1;
        check("cfg_err_set", a_cfg_err, 1);
        check("cfg_no_windows", qa_win.size(), 0);
        clear_q(); acc_cnt = 0;
        send_a(8, 8, 64, 8, 0);
        wait_a(36);
        check_frame_a("resync", 8, 8);
        if (qa_beat.size() > 0) check("resync_first_beat", qa_beat[0], 19);
        check("cfg_err_sticky", a_cfg_err, 1);

        // Reset in the middle of a frame
        clear_q();
        send_a(8, 8, 30, 8, 0);
        check("pre_rst_m_valid", a_m_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_s_ready", a_s_ready, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        check("midrst_m_valid", a_m_valid, 0);
        check("midrst_m_window", a_m_window, 0);
        check("midrst_markers", {a_m_sof, a_m_eol, a_m_eof}, 0);
        check("midrst_cfg_err", a_cfg_err, 0);
        @(posedge clk); #1;
        clear_q();
        send_a(8, 8, 64, 8, 0);
        wait_a(36);
        check_frame_a("postrst", 8, 8);

`ifdef LINE_WINDOW_GEN_EOL_CHECK_EN
        // 7-pixel lines marked with s_eol against a configured width of 8
        check("eol_err_clear", a_eol_err, 0);
        clear_q();
        send_a(8, 8, 49, 7, 0);
        wait_a(25);
        check("eol_err_set", a_eol_err, 1);
        check("eol_count", qa_win.size(), 25);
        hand = 72'h100f0e_090807_020100;
        if (qa_win.size() > 0) check("eol_first_hand", qa_win[0], hand);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
